// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB data-phase response multiplexer with built-in default slave
//
// Registers the decoder's one-hot address-phase select on every edge where the
// bus is ready. It then routes the selected slave's read data, ready and
// response back to the master during the data phase. When no slave was
// selected, a small default-slave FSM answers instead. It gives a zero-wait
// OKAY for IDLE/BUSY transfers and a two-cycle ERROR for NONSEQ/SEQ transfers.
//
// Ports:
//   Hclk, Hresetn  - bus clock; synchronous active-low reset
//   Hsel           - address-phase one-hot (or zero) slave select from the decoder
//   Htrans         - master transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   Hrdata_s       - packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Hreadyout_s    - per-slave ready
//   Hresp_s        - per-slave response (0 OKAY, 1 ERROR)
//   Hrdata         - read data to the master
//   Hready         - global ready, also fed back to every slave
//   Hresp          - response to the master
//   Hsel_dp        - registered data-phase select (debug/monitoring)

`ifndef NUM_SLAVES
`define NUM_SLAVES 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ahb_resp_mux #(
  parameter int NUM_SLAVES = `NUM_SLAVES,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                             Hclk,
  input  logic                             Hresetn,
  input  logic [NUM_SLAVES-1:0]            Hsel,
  input  logic [1:0]                       Htrans,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] Hrdata_s,
  input  logic [NUM_SLAVES-1:0]            Hreadyout_s,
  input  logic [NUM_SLAVES-1:0]            Hresp_s,
  output logic [DATA_WIDTH-1:0]            Hrdata,
  output logic                             Hready,
  output logic                             Hresp,
  output logic [NUM_SLAVES-1:0]            Hsel_dp
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  ds_state_e              state_q, state_d;
  logic [NUM_SLAVES-1:0]  sel_q, sel_d;
  logic                   unmapped_act;

  assign Hsel_dp = sel_q;

  // Response source: the default slave answers unless a mapped slave owns the
  // data phase. The mapped path stays purely combinational from the slave inputs.
  always_comb begin
    Hready = 1'b1;
    Hresp  = 1'b0;
    Hrdata = '0;
    case (state_q)
      DS_ERR1: begin
        Hready = 1'b0;
        Hresp  = 1'b1;
      end
      DS_ERR2: begin
        Hready = 1'b1;
        Hresp  = 1'b1;
      end
      default: begin
        Hready = 1'b1;
        Hresp  = 1'b0;
      end
    endcase
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        Hready = Hreadyout_s[i];
        Hresp  = Hresp_s[i];
        Hrdata = Hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic. A new address phase is accepted only when Hready is high.
  // ERR1 drives Hready low, so it always advances to ERR2. A mapped slave
  // stretching its data phase keeps the default slave parked in IDLE.
  always_comb begin
    unmapped_act = (Hsel == '0) && ((Htrans == 2'b10) || (Htrans == 2'b11));
    sel_d        = sel_q;
    state_d      = state_q;
    if (Hready) begin
      sel_d   = Hsel;
      state_d = unmapped_act ? DS_ERR1 : DS_IDLE;
    end else if (state_q == DS_ERR1) begin
      state_d = DS_ERR2;
    end else begin
      state_d = DS_IDLE;
    end
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      sel_q   <= '0;
      state_q <= DS_IDLE;
    end else begin
      sel_q   <= sel_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb/tb_ahb_resp_mux.sv - directed self-checking bench for ahb_resp_mux

module tb_ahb_resp_mux;

  localparam int NS = 4;
  localparam int DW = 32;

  logic           Hclk;
  logic           Hresetn;
  logic [NS-1:0]  Hsel;
  logic [1:0]     Htrans;
  logic [NS*DW-1:0] Hrdata_s;
  logic [NS-1:0]  Hreadyout_s;
  logic [NS-1:0]  Hresp_s;
  logic [DW-1:0]  Hrdata;
  logic           Hready;
  logic           Hresp;
  logic [NS-1:0]  Hsel_dp;

  logic [DW-1:0]  rd0, rd1, rd2, rd3;

  int total;
  int bad;

  assign Hrdata_s = {rd3, rd2, rd1, rd0};

  ahb_resp_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) dut (
    .Hclk        (Hclk),
    .Hresetn     (Hresetn),
    .Hsel        (Hsel),
    .Htrans      (Htrans),
    .Hrdata_s    (Hrdata_s),
    .Hreadyout_s (Hreadyout_s),
    .Hresp_s     (Hresp_s),
    .Hrdata      (Hrdata),
    .Hready      (Hready),
    .Hresp       (Hresp),
    .Hsel_dp     (Hsel_dp)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rr(input string tag, input logic rdy, input logic rsp);
    #1;
    chk({tag, "_ready"}, {63'd0, Hready}, {63'd0, rdy});
    chk({tag, "_resp"},  {63'd0, Hresp},  {63'd0, rsp});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Hresetn = 1'b0;
    Hsel = '0;
    Htrans = 2'b00;
    Hreadyout_s = 4'b0000;
    Hresp_s = 4'b1111;
    rd0 = 32'h11111111; rd1 = 32'h22222222; rd2 = 32'h33333333; rd3 = 32'h44444444;

    // Reset held for two edges with slave inputs toggling
    tick();
    Hreadyout_s = 4'b1010; Hresp_s = 4'b0101; rd1 = 32'hFFFFFFFF;
    tick();
    #1;
    chk("rst_ready", {63'd0, Hready}, 64'd1);
    chk("rst_resp",  {63'd0, Hresp},  64'd0);
    chk("rst_rdata", {32'd0, Hrdata}, 64'd0);
    chk("rst_seldp", {60'd0, Hsel_dp}, 64'd0);

    // Mapped read from slave1
    Hresetn = 1'b1;
    Hreadyout_s = 4'b1111; Hresp_s = 4'b0000;
    rd1 = 32'hDEADBEEF; rd2 = 32'hAAAA5555;
    Hsel = 4'b0010; Htrans = 2'b10;
    tick();
    Hsel = 4'b0100; Htrans = 2'b10;
    Hreadyout_s[2] = 1'b0;
    #1;
    chk("rd1_rdata", {32'd0, Hrdata}, 64'hDEADBEEF);
    chk("rd1_ready", {63'd0, Hready}, 64'd1);
    chk("rd1_resp",  {63'd0, Hresp},  64'd0);
    chk("rd1_seldp", {60'd0, Hsel_dp}, 64'b0010);

    // Slave2 data phase stretched by three wait cycles; slave0 address meanwhile
    tick();
    Hsel = 4'b0001;
    #1;
    chk("ws1_ready", {63'd0, Hready}, 64'd0);
    chk("ws1_seldp", {60'd0, Hsel_dp}, 64'b0100);
    tick();
    #1;
    chk("ws2_ready", {63'd0, Hready}, 64'd0);
    chk("ws2_seldp", {60'd0, Hsel_dp}, 64'b0100);
    tick();
    #1;
    chk("ws3_ready", {63'd0, Hready}, 64'd0);
    chk("ws3_seldp", {60'd0, Hsel_dp}, 64'b0100);
    tick();
    Hreadyout_s[2] = 1'b1;
    #1;
    chk("ws_done_ready", {63'd0, Hready}, 64'd1);
    chk("ws_done_rdata", {32'd0, Hrdata}, 64'hAAAA5555);
    chk("ws_done_seldp", {60'd0, Hsel_dp}, 64'b0100);
    tick();
    #1;
    chk("s0_seldp", {60'd0, Hsel_dp}, 64'b0001);
    chk("s0_rdata", {32'd0, Hrdata}, 64'h11111111);

    // Unmapped NONSEQ followed by IDLE
    Hsel = 4'b0000; Htrans = 2'b10;
    tick();
    Htrans = 2'b00;
    chk_rr("um_err1", 1'b0, 1'b1);
    chk("um_err1_rdata", {32'd0, Hrdata}, 64'd0);
    chk("um_err1_seldp", {60'd0, Hsel_dp}, 64'd0);
    tick();
    chk_rr("um_err2", 1'b1, 1'b1);
    tick();
    chk_rr("um_idle", 1'b1, 1'b0);

    // Unmapped IDLE and BUSY: single zero-wait OKAY each
    tick();
    chk_rr("um_idle_okay", 1'b1, 1'b0);
    Htrans = 2'b01;
    tick();
    chk_rr("um_busy_okay", 1'b1, 1'b0);

    // Back-to-back unmapped NONSEQ then slave3 read
    rd3 = 32'h12345678;
    Htrans = 2'b10;
    tick();
    chk_rr("b2b_err1a", 1'b0, 1'b1);
    tick();
    chk_rr("b2b_err2a", 1'b1, 1'b1);
    tick();
    Hsel = 4'b1000; Htrans = 2'b10;
    chk_rr("b2b_err1b", 1'b0, 1'b1);
    tick();
    chk_rr("b2b_err2b", 1'b1, 1'b1);
    tick();
    Hsel = 4'b0000; Htrans = 2'b00;
    chk_rr("b2b_s3", 1'b1, 1'b0);
    chk("b2b_s3_rdata", {32'd0, Hrdata}, 64'h12345678);
    chk("b2b_s3_seldp", {60'd0, Hsel_dp}, 64'b1000);

    // Reset during ERR1 abandons the error sequence
    Htrans = 2'b10;
    tick();
    chk_rr("rerr_err1", 1'b0, 1'b1);
    Hresetn = 1'b0; Htrans = 2'b00;
    tick();
    chk_rr("rerr_after_rst", 1'b1, 1'b0);
    Hresetn = 1'b1;
    tick();
    chk_rr("rerr_no_err2", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb_resp_mux.md
# ahb_resp_mux

Data-phase response multiplexer for the AHB bus. It sits directly downstream of the address decoder. It registers the decoder's one-hot `Hsel` at the end of each address phase. During the following data phase it routes the selected slave's `Hrdata`/`Hreadyout`/`Hresp` back to the master. It contains the bus default slave, which returns a two-cycle ERROR response to active transfers that hit no mapped slave.

## Interface
- `NUM_SLAVES`, default `` `NUM_SLAVES `` (global defines header): number of slave ports; equals `Hsel` width.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (global defines header): read data width.
- `Hclk` input 1: bus clock. All state updates on its rising edge.
- `Hresetn` input 1: reset, synchronous, active-low.
- `Hsel` input NUM_SLAVES: address-phase select from the decoder; one-hot or all-zero.
- `Htrans` input 2: master transfer type. 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Hrdata_s` input NUM_SLAVES*DATA_WIDTH: slave read data. Slave i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `Hreadyout_s` input NUM_SLAVES: per-slave ready.
- `Hresp_s` input NUM_SLAVES: per-slave response; 0 OKAY, 1 ERROR.
- `Hrdata` output DATA_WIDTH: read data to the master.
- `Hready` output 1: global ready to the master. The same signal is fed back to all slaves.
- `Hresp` output 1: response to the master.
- `Hsel_dp` output NUM_SLAVES: registered data-phase select, for debug and monitoring.

## Operation
- Data-phase select register `sel_q` (NUM_SLAVES bits):
  - Loads `Hsel` on a rising edge where `Hready`=1.
  - Holds its value while `Hready`=0.
  - `Hsel_dp` = `sel_q`.
- Mapped path, when `sel_q` has bit i set:
  - `Hrdata` = slave i slice.
  - `Hready` = `Hreadyout_s[i]`.
  - `Hresp` = `Hresp_s[i]`.
  - This path is purely combinational from the slave inputs.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2. It is only visible on the outputs when `sel_q`==0.
  - DS_IDLE: outputs `Hready`=1, `Hresp`=0, `Hrdata`=0. This is a zero-wait OKAY, and it covers IDLE/BUSY transfers to unmapped space.
  - DS_ERR1: outputs `Hready`=0, `Hresp`=1, `Hrdata`=0.
  - DS_ERR2: outputs `Hready`=1, `Hresp`=1, `Hrdata`=0.
  - Let unmapped_act = (`Hsel`==0) && `Htrans[1]`.
  - Transitions, evaluated only when `Hready`=1 (states DS_IDLE, DS_ERR2, or any mapped data phase with ready high): next state = DS_ERR1 if unmapped_act, else DS_IDLE.
  - DS_ERR1 always moves to DS_ERR2 on the next edge.
  - While a mapped slave holds `Hready`=0, the FSM stays in DS_IDLE.
- `Hsel` with more than one bit set is illegal; behaviour is don't-care. The decoder guarantees one-hot-or-zero.
- The FSM state and `sel_q` form the entire state of the block. No other storage.

## Timing
- Reset: synchronous, applied on any edge where `Hresetn`=0.
  - `sel_q` clears to 0 and the FSM goes to DS_IDLE.
  - Outputs after that edge: `Hready`=1, `Hresp`=0, `Hrdata`=0, `Hsel_dp`=0.
- Reset mid-operation behaves the same. A pending slave wait or a default ERR1/ERR2 sequence is abandoned at the reset edge, with no residual ERROR cycle.
- Latency: the select is one cycle. The address phase in cycle N selects the data-phase source in cycle N+1.
  - Slave-to-master data/ready/resp has zero cycles of latency (combinational).
- Slave wait states: while the selected `Hreadyout_s`=0, `sel_q` holds.
  - A new `Hsel`/`Htrans` presented during that time is ignored until the cycle where `Hready`=1.
- Unmapped active transfer:
  - Edge k captures it (`Hready`=1, unmapped_act).
  - Cycle k+1: `Hready`=0, `Hresp`=1.
  - Cycle k+2: `Hready`=1, `Hresp`=1.
- Back-to-back unmapped transfers: ERR2 accepts the next address phase, so the output sequence is ERR1, ERR2, ERR1, ERR2 with no idle gap.
- Mapped-to-unmapped and unmapped-to-mapped switching happens at the single edge where `Hready`=1. No bubble is inserted.
- `Hsel_dp` changes only on edges with `Hready`=1 or reset.

## Test plan
NUM_SLAVES=4, DATA_WIDTH=32 throughout.
- Reset: hold `Hresetn`=0 for 2 edges with slave inputs toggling -> `Hready`=1, `Hresp`=0, `Hrdata`=0, `Hsel_dp`=0.
- Mapped read:
  - Stimulus: `Hsel`=0010, `Htrans`=10. Slave1 drives `Hrdata` 0xDEADBEEF, `Hreadyout_s[1]`=1.
  - Required: the next cycle shows `Hrdata`=0xDEADBEEF, `Hready`=1, `Hresp`=0, `Hsel_dp`=0010.
- Wait states:
  - Stimulus: select slave2, `Hreadyout_s[2]`=0 for 3 cycles, while `Hsel`=0001 is presented meanwhile.
  - Required: `Hready`=0 for 3 cycles and `Hsel_dp` stays 0100. `Hsel_dp` becomes 0001 only after the edge where ready returns to 1.
- Unmapped:
  - `Hsel`=0000, `Htrans`=10 -> `Hready`/`Hresp` = 0/1 then 1/1, then 1/0 if followed by IDLE.
  - `Hsel`=0000, `Htrans`=00 -> single OKAY cycle, `Hready`=1, `Hresp`=0.
- Back-to-back unmapped (two NONSEQ) followed by a slave3 read of 0x12345678 -> ERR1, ERR2, ERR1, ERR2, then `Hrdata`=0x12345678 with no gap.
- Reset asserted during DS_ERR1 -> the next cycle shows `Hready`=1, `Hresp`=0, and no ERR2 cycle appears.
